// File: rtl/fsm_job_launcher_pkg.sv
// Shared types and defaults for the go/done job launcher.
package fsm_launch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_CYC_W   = 16;
  localparam int DEF_TIMEOUT = 64;

  // A timer that must reach TIMEOUT-1; never narrower than one bit.
  function automatic int timer_w(input int timeout);
    return ($clog2(timeout) > 0) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/fsm_job_launcher_if.sv
// Request/response handshake bundle between host and launcher.
interface fsm_job_launcher_if
  import fsm_launch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int CYC_W = DEF_CYC_W
);
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CNT_W-1:0] rsp_runs;
  logic             rsp_timeout;
  logic [CYC_W-1:0] rsp_cycles;

  modport master (
    output req_valid, req_count, rsp_ready,
    input  req_ready, rsp_valid, rsp_runs, rsp_timeout, rsp_cycles
  );

  modport slave (
    input  req_valid, req_count, rsp_ready,
    output req_ready, rsp_valid, rsp_runs, rsp_timeout, rsp_cycles
  );
endinterface

// File: rtl/fsm_job_launcher_wait_timer.sv
// Clear/enable counter flagging the final permitted WAIT cycle.
module wait_timer
  import fsm_launch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int TW = timer_w(TIMEOUT);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_tc = (r_cnt == TW'(TIMEOUT - 1));
endmodule

// File: rtl/fsm_job_launcher.sv
// Job launcher: re-arms, starts and times one sticky-done worker per run.
module fsm_job_launcher
  import fsm_launch_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CYC_W   = DEF_CYC_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  fsm_job_launcher_if.slave   bus,
  output logic                wrk_rst,
  output logic                wrk_go,
  input  logic                wrk_done,
  output logic                busy
);

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_runs;
  logic             r_timeout;
  logic [CYC_W-1:0] r_cycles;
  logic [CNT_W-1:0] w_runs_inc;
  logic             w_tc;
  logic             w_accept;
  logic             w_active;

  assign w_runs_inc = r_runs + CNT_W'(1);
  assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
  assign w_active   = (r_state == S_ARM) || (r_state == S_LAUNCH) || (r_state == S_WAIT);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .i_clr(r_state == S_LAUNCH),
    .i_en (r_state == S_WAIT),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Done takes priority over the terminal count in the same WAIT cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_next = (bus.req_count == '0) ? S_REPORT : S_ARM;
        end
      end
      S_ARM:    w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (wrk_done) begin
          w_next = (w_runs_inc == r_target) ? S_REPORT : S_ARM;
        end else if (w_tc) begin
          w_next = S_REPORT;
        end
      end
      S_REPORT: begin
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target  <= '0;
      r_runs    <= '0;
      r_timeout <= 1'b0;
      r_cycles  <= '0;
    end else if (w_accept) begin
      r_target  <= bus.req_count;
      r_runs    <= '0;
      r_timeout <= 1'b0;
      r_cycles  <= '0;
    end else begin
      if (w_active) begin
        r_cycles <= sat_inc(r_cycles);
      end
      if (r_state == S_WAIT) begin
        if (wrk_done) begin
          r_runs <= w_runs_inc;
        end else if (w_tc) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // Worker reset follows launcher reset combinationally so an abort clears it too.
  assign wrk_rst         = rst || (r_state == S_ARM);
  assign wrk_go          = (r_state == S_LAUNCH);
  assign busy            = (r_state != S_IDLE);
  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.rsp_valid   = (r_state == S_REPORT);
  assign bus.rsp_runs    = r_runs;
  assign bus.rsp_timeout = r_timeout;
  assign bus.rsp_cycles  = r_cycles;

endmodule
